// File: rtl/pkt_gen_multi_if.sv
// Beat stream from the packet generator towards the router fabric.
interface pkt_gen_multi_if #(
    parameter int DATA_W = 8,
    parameter int DEST_W = 2
);
    logic              valid;
    logic              ready;
    logic [DEST_W-1:0] dest_addr;
    logic [1:0]        packet_type;
    logic [DATA_W-1:0] payload;
    logic              sop;
    logic              eop;

    modport master (
        output valid, dest_addr, packet_type, payload, sop, eop,
        input  ready
    );

    modport slave (
        input  valid, dest_addr, packet_type, payload, sop, eop,
        output ready
    );
endinterface

// File: rtl/pkt_gen_multi.sv
// Multi-beat packet generator: programmable length, count, destination
// mode and type, with an optional idle gap between packets.
module pkt_gen_multi #(
    parameter int DATA_W = 8,
    parameter int N_DEST = 4,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = 8,
    parameter int GAP    = 0,
    localparam int DEST_W = $clog2(N_DEST)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [CNT_W-1:0]  cfg_num_pkts,
    input  logic              cfg_rr,
    input  logic [DEST_W-1:0] cfg_dest,
    input  logic [1:0]        cfg_type,
    pkt_gen_multi_if.master   st,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pkt_count
);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [DEST_W:0] N_DEST_L = (DEST_W + 1)'(N_DEST);
    localparam logic [DEST_W-1:0] DEST_LAST = DEST_W'(N_DEST - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rr_q, rr_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [1:0]        type_q, type_d;
    logic [DATA_W-1:0] payload_q, payload_d;
    logic              abort_q, abort_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              done_q, done_d;

    logic              last_beat;
    logic              abort_pend;
    logic [CNT_W-1:0]  cnt_inc;

    assign last_beat  = (beat_q == len_q);
    assign abort_pend = abort_q | abort;
    assign cnt_inc    = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        beat_d    = beat_q;
        num_d     = num_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        dest_d    = dest_q;
        type_d    = type_q;
        payload_d = payload_q;
        abort_d   = abort_q;
        gap_d     = gap_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d     = cfg_len;
                    num_d     = cfg_num_pkts;
                    rr_d      = cfg_rr;
                    type_d    = cfg_type;
                    dest_d    = ({1'b0, cfg_dest} >= N_DEST_L) ? '0 : cfg_dest;
                    beat_d    = '0;
                    cnt_d     = '0;
                    payload_d = '0;
                    abort_d   = abort;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                abort_d = abort_pend;
                if (st.ready) begin
                    payload_d = payload_q + DATA_W'(1);
                    if (last_beat) begin
                        beat_d = '0;
                        cnt_d  = cnt_inc;
                        if (rr_q)
                            dest_d = (dest_q == DEST_LAST) ? '0 : dest_q + DEST_W'(1);
                        if (((num_q != '0) && (cnt_inc == num_q)) || abort_pend) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else if (GAP > 0) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                    end
                end
            end
            S_GAP: begin
                abort_d = abort_pend;
                if (abort_pend) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            beat_q    <= '0;
            num_q     <= '0;
            cnt_q     <= '0;
            rr_q      <= 1'b0;
            dest_q    <= '0;
            type_q    <= '0;
            payload_q <= '0;
            abort_q   <= 1'b0;
            gap_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            num_q     <= num_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            dest_q    <= dest_d;
            type_q    <= type_d;
            payload_q <= payload_d;
            abort_q   <= abort_d;
            gap_q     <= gap_d;
            done_q    <= done_d;
        end
    end

    assign st.valid       = (state_q == S_SEND);
    assign st.sop         = st.valid && (beat_q == '0);
    assign st.eop         = st.valid && last_beat;
    assign st.dest_addr   = dest_q;
    assign st.packet_type = type_q;
    assign st.payload     = payload_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign pkt_count      = cnt_q;
endmodule
